// File: rtl/elastic_pkg.sv
// -----------------------------------------------------------------------------
// elastic_pkg
// Shared definitions for the elastic_unpack slice: default stream width and
// shift amount, the skid-buffer occupancy enum and the error counter width.
// -----------------------------------------------------------------------------
package elastic_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int SHIFT_DEF  = 2;
   localparam int ERR_CNT_W  = 16;

   // Occupancy of the two-entry skid buffer (main, skid).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/elastic_err_cnt.sv
// -----------------------------------------------------------------------------
// elastic_err_cnt
// Saturating event counter. Increments by one on every cycle inc_i is high and
// sticks at all-ones.
//
// Ports
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset, clears the count
//   inc_i  in   count one event this cycle
//   cnt_o  out  ERR_CNT_W-bit count
// -----------------------------------------------------------------------------
module elastic_err_cnt
   import elastic_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   output logic [ERR_CNT_W-1:0] cnt_o
);

   logic [ERR_CNT_W-1:0] cnt_q;
   logic [ERR_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {ERR_CNT_W{1'b1}})) begin
         cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_unpack.sv
// -----------------------------------------------------------------------------
// elastic_unpack
// Two-entry skid buffer that accepts left-shifted words, stores them already
// shifted right by SHIFT (zero-fill) and presents them downstream. t0_ready is
// a flop, so i0_ready never reaches it combinationally. Beats whose low SHIFT
// bits are non-zero are malformed; they are still forwarded.
//
// Build option
//   ELASTIC_UNPACK_ERR_CNT_EN  defined: err_cnt counts accepted malformed beats
//                              (saturating). Undefined: err_cnt is tied to 0.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   t0_data   in   DATA_W upstream word
//   t0_valid  in   upstream word valid
//   t0_ready  out  block accepts a beat this cycle (registered)
//   i0_data   out  DATA_W unpacked word (registered)
//   i0_valid  out  unpacked word valid
//   i0_ready  in   downstream accepts i0_data
//   err_cnt   out  16-bit malformed-beat count
// -----------------------------------------------------------------------------
module elastic_unpack
   import elastic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SHIFT  = SHIFT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    t0_data,
   input  logic                 t0_valid,
   output logic                 t0_ready,
   output logic [DATA_W-1:0]    i0_data,
   output logic                 i0_valid,
   input  logic                 i0_ready,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              rdy_q;
   logic              accept;
   logic              pop;
   logic [DATA_W-1:0] in_shifted;

   assign accept     = t0_valid & rdy_q;
   assign pop        = i0_valid & i0_ready;
   // Entries are stored already shifted so i0_data comes straight off main_q.
   assign in_shifted = t0_data >> SHIFT;

   // State and storage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         // Ready for the coming cycle is known from the next occupancy.
         rdy_q   <= (state_d != ST_TWO);
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_ONE;
         ST_ONE: begin
            if (accept && !pop)      state_d = ST_TWO;
            else if (pop && !accept) state_d = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Output and storage-load logic
   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      i0_valid = (state_q != ST_EMPTY);
      case (state_q)
         ST_EMPTY: if (accept) main_d = in_shifted;
         ST_ONE: begin
            // With a simultaneous pop the new beat replaces main directly.
            if (accept && pop) main_d = in_shifted;
            else if (accept)   skid_d = in_shifted;
         end
         ST_TWO:   if (pop) main_d = skid_q;
         default: ;
      endcase
   end

   assign t0_ready = rdy_q;
   assign i0_data  = main_q;

`ifdef ELASTIC_UNPACK_ERR_CNT_EN
   localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'((64'd1 << SHIFT) - 64'd1);

   logic malformed;
   assign malformed = |(t0_data & LOW_MASK);

   elastic_err_cnt u_err_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (accept & malformed),
      .cnt_o (err_cnt)
   );
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_elastic_unpack.sv
module tb_elastic_unpack;

   localparam int DATA_W = 32;
   localparam int SHIFT  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] t0_data;
   logic              t0_valid;
   logic              t0_ready;
   logic [DATA_W-1:0] i0_data;
   logic              i0_valid;
   logic              i0_ready;
   logic [15:0]       err_cnt;

   int                errors = 0;
   int                checks = 0;
   int                pops   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_v;
   logic [15:0]       exp_err = 16'd0;

   always #5 clk = ~clk;

   elastic_unpack #(.DATA_W(DATA_W), .SHIFT(SHIFT)) dut (
      .clk      (clk),
      .rst      (rst),
      .t0_data  (t0_data),
      .t0_valid (t0_valid),
      .t0_ready (t0_ready),
      .i0_data  (i0_data),
      .i0_valid (i0_valid),
      .i0_ready (i0_ready),
      .err_cnt  (err_cnt)
   );

   // Scoreboard: inputs are driven 1 time unit after posedge, so at negedge
   // handshakes for the coming edge are stable. Pops are handled before pushes.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (i0_valid && i0_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_output: got i0_data=%h, required none (scoreboard empty)", i0_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (i0_data !== exp_v) begin
                  errors++;
                  $display("FAIL sb_data: got i0_data=%h, required %h", i0_data, exp_v);
               end
            end
         end
         if (t0_valid && t0_ready) begin
            exp_q.push_back(t0_data >> SHIFT);
`ifdef ELASTIC_UNPACK_ERR_CNT_EN
            if (((t0_data & 32'h3) != 0) && (exp_err != 16'hFFFF)) exp_err++;
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      t0_valid = 1'b0;
      t0_data = '0;
      i0_ready = 1'b0;
      repeat (2) step();
      checks += 4;
      if (t0_ready !== 1'b0) begin errors++; $display("FAIL rst_t0_ready: got %b, required 0", t0_ready); end
      if (i0_valid !== 1'b0) begin errors++; $display("FAIL rst_i0_valid: got %b, required 0", i0_valid); end
      if (i0_data !== 32'h0) begin errors++; $display("FAIL rst_i0_data: got %h, required 0", i0_data); end
      if (err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err_cnt: got %h, required 0", err_cnt); end
      rst = 1'b0;
      step();
      checks++;
      if (t0_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, required 1", t0_ready); end
   endtask

   task automatic test_single();
      i0_ready = 1'b1;
      t0_data = 32'h0000_0010;
      t0_valid = 1'b1;
      step();
      t0_valid = 1'b0;
      checks += 2;
      if (i0_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", i0_valid); end
      if (i0_data !== 32'h0000_0004) begin errors++; $display("FAIL single_data: got %h, required 00000004", i0_data); end
      step();
      checks++;
      if (i0_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b, required 0", i0_valid); end
      wait_drain("single");
   endtask

   task automatic test_backpressure();
      logic acc;
      i0_ready = 1'b0;
      t0_data = 32'h4; t0_valid = 1'b1;
      step();
      t0_data = 32'h8;
      step();
      t0_data = 32'hC;
      checks++;
      if (t0_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b, required 0", t0_ready); end
      repeat (3) step();
      checks += 3;
      if (t0_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b, required 0", t0_ready); end
      if (i0_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b, required 1", i0_valid); end
      if (i0_data !== 32'h1) begin errors++; $display("FAIL bp_hold_data: got %h, required 00000001", i0_data); end
      i0_ready = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         acc = t0_ready;
         step();
         if (acc) break;
      end
      t0_valid = 1'b0;
      checks++;
      if (!acc) begin errors++; $display("FAIL bp_third_accept: got none, required acceptance within 10 cycles"); end
      wait_drain("bp");
   endtask

   task automatic test_streaming();
      int p0;
      p0 = pops;
      i0_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         t0_data = $urandom() & 32'hFFFF_FFFC;
         t0_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (t0_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: beat %0d got %b, required 1", i, t0_ready); end
         step();
      end
      t0_valid = 1'b0;
      wait_drain("stream");
      checks++;
      if (pops - p0 != 100) begin errors++; $display("FAIL stream_count: got %0d outputs, required 100", pops - p0); end
   endtask

   task automatic test_malformed();
      logic [DATA_W-1:0] beats [3];
      logic [15:0] exp_const;
      beats[0] = 32'h3; beats[1] = 32'h5; beats[2] = 32'h8;
`ifdef ELASTIC_UNPACK_ERR_CNT_EN
      exp_const = 16'd2;
`else
      exp_const = 16'd0;
`endif
      i0_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         t0_data = beats[i];
         t0_valid = 1'b1;
         step();
      end
      t0_valid = 1'b0;
      wait_drain("malformed");
      checks++;
      if (err_cnt !== exp_const) begin errors++; $display("FAIL malformed_err_cnt: got %0d, required %0d", err_cnt, exp_const); end
   endtask

   task automatic test_reset_mid();
      i0_ready = 1'b0;
      t0_data = 32'h20; t0_valid = 1'b1;
      step();
      t0_data = 32'h24;
      step();
      t0_valid = 1'b0;
      checks += 2;
      if (i0_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b, required 1", i0_valid); end
      if (t0_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre_ready: got %b, required 0", t0_ready); end
      #2 rst = 1'b1;
      #1;
      checks += 4;
      if (i0_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", i0_valid); end
      if (t0_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, required 0", t0_ready); end
      if (i0_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h, required 0", i0_data); end
      if (err_cnt !== 16'h0) begin errors++; $display("FAIL midrst_err_cnt: got %h, required 0", err_cnt); end
      exp_q.delete();
      exp_err = 16'd0;
      @(posedge clk);
      #2 rst = 1'b0;
      step();
      checks++;
      if (t0_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b, required 1", t0_ready); end
      i0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (i0_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: cycle %0d got i0_valid=%b, required 0", i, i0_valid); end
      end
   endtask

`ifdef ELASTIC_UNPACK_ERR_CNT_EN
   task automatic test_saturation();
      i0_ready = 1'b1;
      t0_data = 32'h1;
      t0_valid = 1'b1;
      repeat (65537) step();
      t0_valid = 1'b0;
      wait_drain("sat");
      checks += 2;
      if (err_cnt !== exp_err) begin errors++; $display("FAIL sat_model: got %h, required %h", err_cnt, exp_err); end
      if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h, required ffff", err_cnt); end
      t0_data = 32'h2;
      t0_valid = 1'b1;
      step();
      t0_valid = 1'b0;
      wait_drain("sat_hold");
      checks++;
      if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h, required ffff", err_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_malformed();
      test_reset_mid();
`ifdef ELASTIC_UNPACK_ERR_CNT_EN
      test_saturation();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
